// File: rtl/npc_btb_predict.sv
// Fetch-stage next-PC unit: PC register, direct-mapped BTB with 2-bit counters, EX redirect/flush.
// Define NPC_PREDICT_EN to build the BTB; otherwise the unit predicts static not-taken.

`ifndef NPC_PLUS4
`define NPC_PLUS4  3'd0
`endif
`ifndef NPC_BRANCH
`define NPC_BRANCH 3'd1
`endif
`ifndef NPC_JUMP
`define NPC_JUMP   3'd2
`endif
`ifndef NPC_JALR
`define NPC_JALR   3'd3
`endif

module npc_btb_predict #(
  parameter int               WIDTH    = 32,
  parameter int               ENTRIES  = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic [2:0]       ex_op,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic             ex_taken,
  input  logic [WIDTH-1:0] ex_target,
  input  logic             ex_pred_taken,
  input  logic [WIDTH-1:0] ex_pred_target,
  output logic [WIDTH-1:0] pc,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  output logic             flush
);

  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] actual;
  logic             is_branch;
  logic             is_jump;
  logic             resolve;
  logic             mispredict;

  assign pc_plus4 = pc + WIDTH'(4);

  // NOTE: every signal written in an always_comb gets a value on every path
  // (here, straight-line assignments) so no latch can be inferred.
  always_comb begin
    is_branch  = (ex_op == `NPC_BRANCH);
    is_jump    = (ex_op == `NPC_JUMP) || (ex_op == `NPC_JALR);
    resolve    = ex_valid & (is_branch | is_jump);
    actual     = ex_taken ? ex_target : ex_pc + WIDTH'(4);
    mispredict = (ex_taken != ex_pred_taken) |
                 (ex_taken & (ex_target != ex_pred_target));
  end

  assign flush = resolve & mispredict;

`ifdef NPC_PREDICT_EN
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = WIDTH - IDX_W - 2;

  logic             btb_valid  [ENTRIES];
  logic [1:0]       btb_cnt    [ENTRIES];
  logic [TAG_W-1:0] btb_tag    [ENTRIES];
  logic [WIDTH-1:0] btb_target [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  logic             e_hit;

  assign f_idx = pc[IDX_W+1:2];
  assign f_tag = pc[WIDTH-1:IDX_W+2];
  assign f_hit = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
  assign e_idx = ex_pc[IDX_W+1:2];
  assign e_tag = ex_pc[WIDTH-1:IDX_W+2];
  assign e_hit = btb_valid[e_idx] && (btb_tag[e_idx] == e_tag);

  // Lookup reads pre-edge contents, so a same-index update is seen next cycle.
  assign pred_taken  = f_hit & btb_cnt[f_idx][1];
  assign pred_target = pred_taken ? btb_target[f_idx] : pc_plus4;

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        btb_cnt[i]   <= 2'b01;
      end
    end else if (resolve) begin
      if (is_jump) begin
        btb_valid[e_idx] <= 1'b1;
        btb_cnt[e_idx]   <= 2'b11;
      end else if (e_hit) begin
        if (ex_taken)
          btb_cnt[e_idx] <= (btb_cnt[e_idx] == 2'b11) ? 2'b11 : btb_cnt[e_idx] + 2'b01;
        else
          btb_cnt[e_idx] <= (btb_cnt[e_idx] == 2'b00) ? 2'b00 : btb_cnt[e_idx] - 2'b01;
      end else if (ex_taken) begin
        btb_valid[e_idx] <= 1'b1;
        btb_cnt[e_idx]   <= 2'b10;
      end
    end
  end

  // NOTE: tag/target storage has no reset; an entry's valid bit gates every
  // use of it, so only valid and the counters need clearing.
  always_ff @(posedge clk) begin
    if (!rst && resolve && (is_jump || ex_taken)) begin
      btb_tag[e_idx]    <= e_tag;
      btb_target[e_idx] <= ex_target;
    end
  end
`else
  assign pred_taken  = 1'b0;
  assign pred_target = pc_plus4;
`endif

  // Redirect outranks stall; a stalled fetch simply holds its pc.
  always_comb begin
    pc_next = pred_target;
    if (flush)
      pc_next = actual;
    else if (stall)
      pc_next = pc;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end

endmodule

// File: tb/tb_npc_btb_predict.sv
// Bench for npc_btb_predict: directed scenarios plus random traffic, scoreboarded
// against a behavioural next-PC/BTB model. Honours NPC_PREDICT_EN like the design.

`ifndef NPC_PLUS4
`define NPC_PLUS4  3'd0
`endif
`ifndef NPC_BRANCH
`define NPC_BRANCH 3'd1
`endif
`ifndef NPC_JUMP
`define NPC_JUMP   3'd2
`endif
`ifndef NPC_JALR
`define NPC_JALR   3'd3
`endif

module tb_npc_btb_predict;

  localparam int          WIDTH    = 32;
  localparam int          ENTRIES  = 16;
  localparam int          IDX_W    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef NPC_PREDICT_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        ex_valid = 1'b0;
  logic [2:0]  ex_op = `NPC_PLUS4;
  logic [31:0] ex_pc = '0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        flush;

  always #5 clk = ~clk;

  npc_btb_predict #(.WIDTH(WIDTH), .ENTRIES(ENTRIES), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .pc(pc), .pred_taken(pred_taken), .pred_target(pred_target), .flush(flush)
  );

  typedef struct {
    logic [31:0] pc;
    bit          pt;
    logic [31:0] ptgt;
    bit          fl;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural pc plus a table of predictor entries.
  bit          m_known = 1'b0;
  logic [31:0] m_pc;
  bit          m_v   [ENTRIES];
  logic [31:0] m_tag [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  int          m_cnt [ENTRIES];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % ENTRIES);
  endfunction

  function automatic void predict(input logic [31:0] a, output bit t, output logic [31:0] n);
    int i = idx_of(a);
    t = PRED_EN && m_v[i] && (m_tag[i] == (a >> (IDX_W + 2))) && (m_cnt[i] >= 2);
    n = t ? m_tgt[i] : a + 32'd4;
  endfunction

  function automatic bit resolves();
    return ex_valid && (ex_op inside {`NPC_BRANCH, `NPC_JUMP, `NPC_JALR});
  endfunction

  function automatic bit mispredicted();
    return resolves() && ((ex_taken != ex_pred_taken) ||
                          (ex_taken && ex_target != ex_pred_target));
  endfunction

  // Applies one clock edge to the model using the inputs held across it.
  task automatic advance();
    bit          t;
    logic [31:0] n;
    int          i;
    bit          hit;
    if (rst) begin
      m_known = 1'b1;
      m_pc    = RESET_PC;
      for (int k = 0; k < ENTRIES; k++) begin
        m_v[k]   = 1'b0;
        m_cnt[k] = 1;
      end
      return;
    end
    if (!m_known) return;
    predict(m_pc, t, n);
    if (mispredicted())  m_pc = ex_taken ? ex_target : ex_pc + 32'd4;
    else if (!stall)     m_pc = n;
    if (PRED_EN && resolves()) begin
      i   = idx_of(ex_pc);
      hit = m_v[i] && (m_tag[i] == (ex_pc >> (IDX_W + 2)));
      if (ex_op != `NPC_BRANCH) begin
        m_v[i] = 1'b1; m_tag[i] = ex_pc >> (IDX_W + 2); m_tgt[i] = ex_target; m_cnt[i] = 3;
      end else if (hit) begin
        m_cnt[i] = ex_taken ? ((m_cnt[i] == 3) ? 3 : m_cnt[i] + 1)
                            : ((m_cnt[i] == 0) ? 0 : m_cnt[i] - 1);
        if (ex_taken) m_tgt[i] = ex_target;
      end else if (ex_taken) begin
        m_v[i] = 1'b1; m_tag[i] = ex_pc >> (IDX_W + 2); m_tgt[i] = ex_target; m_cnt[i] = 2;
      end
    end
  endtask

  task automatic drive(input bit r, input bit s, input bit ev, input logic [2:0] op,
                       input logic [31:0] epc, input bit tk, input logic [31:0] tg,
                       input bit pt, input logic [31:0] ptg);
    exp_t e;
    @(posedge clk);
    #1;
    advance();
    rst = r; stall = s; ex_valid = ev; ex_op = op; ex_pc = epc;
    ex_taken = tk; ex_target = tg; ex_pred_taken = pt; ex_pred_target = ptg;
    if (m_known) begin
      e.pc = m_pc;
      predict(m_pc, e.pt, e.ptgt);
      e.fl = mispredicted();
      sb.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input bit s);
    drive(1'b0, s, 1'b0, `NPC_PLUS4, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Cold-predicted taken branch at 'from' forces fetch to 'to'.
  task automatic redirect(input logic [31:0] from, input logic [31:0] to);
    drive(1'b0, 1'b0, 1'b1, `NPC_BRANCH, from, 1'b1, to, 1'b0, from + 32'd4);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    if ($urandom_range(0, 7) == 0) a = a | 32'hABC0_0000;
    return a;
  endfunction

  task automatic rand_step();
    bit          r, s, ev, tk, pt;
    int          k;
    logic [2:0]  op;
    logic [31:0] epc, tg, ptg;
    r   = ($urandom_range(0, 99) == 0);
    s   = ($urandom_range(0, 3) == 0);
    ev  = ($urandom_range(0, 9) < 6);
    k   = $urandom_range(0, 9);
    op  = (k < 4) ? `NPC_BRANCH : (k == 4) ? `NPC_JUMP : (k == 5) ? `NPC_JALR :
          (k == 6) ? `NPC_PLUS4 : 3'($urandom_range(4, 7));
    epc = rand_addr();
    tg  = rand_addr();
    tk  = (op == `NPC_JUMP || op == `NPC_JALR) ? 1'b1 : 1'($urandom_range(0, 1));
    if ($urandom_range(0, 1) == 1) begin
      predict(epc, pt, ptg);
    end else begin
      pt  = 1'($urandom_range(0, 1));
      ptg = pt ? rand_addr() : epc + 32'd4;
    end
    drive(r, s, ev, op, epc, tk, tg, pt, ptg);
  endtask

  // Monitor: compares every presented cycle against the queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        automatic exp_t e = sb.pop_front();
        check("pc", pc, e.pc);
        check("pred_taken", {31'b0, pred_taken}, {31'b0, e.pt});
        check("pred_target", pred_target, e.ptgt);
        check("flush", {31'b0, flush}, {31'b0, e.fl});
      end
    end
  end

  initial begin
    // Reset, free run, stall
    idle(1'b0);
    check("reset_pc", pc, RESET_PC);
    check("reset_flush", {31'b0, flush}, 32'd0);
    check("reset_pred_taken", {31'b0, pred_taken}, 32'd0);
    idle(1'b0); idle(1'b0); idle(1'b0);
    check("run_pc_0c", pc, 32'h0C);
    idle(1'b1); idle(1'b1); idle(1'b0);
    check("stall_hold", pc, 32'h10);
    idle(1'b0);
    check("stall_release", pc, 32'h14);

    // Cold taken branch, then refetch
    drive(1'b0, 1'b0, 1'b1, `NPC_BRANCH, 32'h20, 1'b1, 32'h80, 1'b0, 32'h24);
    check("cold_branch_flush", {31'b0, flush}, 32'd1);
    redirect(32'h84, 32'h20);
    check("cold_branch_target", pc, 32'h80);
    idle(1'b1);
    check("refetch_pred_taken", {31'b0, pred_taken}, {31'b0, PRED_EN});
    check("refetch_pred_target", pred_target, PRED_EN ? 32'h80 : 32'h24);

    // Two not-taken resolves walk the counter down
    drive(1'b0, 1'b1, 1'b1, `NPC_BRANCH, 32'h20, 1'b0, 32'h80, 1'b0, 32'h24);
    check("nt1_no_flush", {31'b0, flush}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, `NPC_BRANCH, 32'h20, 1'b0, 32'h80, 1'b1, 32'h80);
    check("nt2_flush", {31'b0, flush}, 32'd1);
    redirect(32'h88, 32'h20);
    check("nt2_redirect", pc, 32'h24);
    idle(1'b1);
    check("nt_pred_taken", {31'b0, pred_taken}, 32'd0);
    check("nt_pred_target", pred_target, 32'h24);

    // JALR retarget, second redirect under stall
    drive(1'b0, 1'b0, 1'b1, `NPC_JALR, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    check("jalr1_flush", {31'b0, flush}, 32'd1);
    drive(1'b0, 1'b1, 1'b1, `NPC_JALR, 32'h40, 1'b1, 32'h200, 1'b1, 32'h100);
    check("jalr1_pc", pc, 32'h100);
    check("jalr2_flush", {31'b0, flush}, 32'd1);
    redirect(32'h8C, 32'h40);
    check("jalr2_pc_under_stall", pc, 32'h200);
    idle(1'b1);
    check("jalr_pred_target", pred_target, PRED_EN ? 32'h200 : 32'h44);

    // Unknown and PLUS4 ops never flush
    drive(1'b0, 1'b1, 1'b1, 3'd5, 32'h40, 1'b1, 32'h300, 1'b0, 32'h44);
    check("unknown_op_no_flush", {31'b0, flush}, 32'd0);
    drive(1'b0, 1'b1, 1'b1, `NPC_PLUS4, 32'h40, 1'b1, 32'h300, 1'b0, 32'h44);
    check("plus4_op_no_flush", {31'b0, flush}, 32'd0);

    // Wrap at top of address space, then reset during a redirect
    redirect(32'h90, 32'hFFFF_FFFC);
    check("no_op_pc_held", pc, 32'h40);
    idle(1'b1);
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pred_target", pred_target, 32'h0);
    drive(1'b1, 1'b1, 1'b1, `NPC_BRANCH, 32'h94, 1'b1, 32'h300, 1'b0, 32'h98);
    redirect(32'h84, 32'h20);
    check("rst_over_redirect", pc, RESET_PC);
    redirect(32'h88, 32'h40);
    check("post_rst_miss_20", {31'b0, pred_taken}, 32'd0);
    idle(1'b1);
    check("post_rst_miss_40", {31'b0, pred_taken}, 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) rand_step();
    idle(1'b0);
    idle(1'b0);

    for (int k = 0; k < 5 && sb.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
